btn_debounce_multi: RTL and testbench
=====================================

# btn_debounce_multi

Parametrised multi-channel push-button conditioner for the board buttons. Each channel is synchronised into the `clk_oled` domain, debounced with a per-channel stability counter, and turned into single-cycle press and release pulses, a long-press level, and an optional auto-repeat pulse train. It sits between the raw button pins and all menu and OLED control logic, and replaces the per-button two-flop edge pulsers.

## Interface
- `N`, 5: number of button channels.
- `STABLE_CYCLES`, 4: consecutive `clk_oled` cycles a synchronised input must differ from the debounced state before the state flips. Must be ≥1.
- `HOLD_CYCLES`, 10: cycles the debounced state must stay pressed before `long_press` asserts. Must be ≥1.
- `REPEAT_EN`, 1: 1 enables auto-repeat pulses; 0 forces `repeat` to 0.
- `REPEAT_CYCLES`, 3: period of `repeat` pulses while long-pressed. Must be ≥1.
- `clk_oled`, input, 1: single clock for the block. All flops are on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `btn`, input, N: raw asynchronous button levels. 1 means pressed.
- `state`, output, N: debounced level per channel.
- `press`, output, N: 1-cycle pulse on each debounced 0→1 transition.
- `release`, output, N: 1-cycle pulse on each debounced 1→0 transition.
- `long_press`, output, N: level. High while the channel has been held for at least HOLD_CYCLES.
- `repeat`, output, N: 1-cycle auto-repeat pulses.

## Operation
- Channels are fully independent. Each channel has its own logic, described below.
- **Synchroniser.** Two flops, `sync1 <= btn[i]` and `sync2 <= sync1`. Only `sync2` is used downstream.
- **Debounce counter.** Width is `$clog2(STABLE_CYCLES+1)`.
  - If `sync2 == state`, the counter clears to 0.
  - If `sync2 != state` and the counter is below STABLE_CYCLES-1, the counter increments.
  - If `sync2 != state` and the counter equals STABLE_CYCLES-1, then on that edge `state` toggles and the counter clears.
- **Glitch rejection.** A mismatch shorter than STABLE_CYCLES cycles never changes `state`. Any single matching cycle restarts the count from 0.
- **Press and release pulses.** Both are registered.
  - `press` is 1 for exactly the cycle after the edge that sets `state` to 1.
  - `release` is 1 for exactly the cycle after the edge that clears `state`.
  - `press` and `release` are never both high on one channel.
- **Hold counter.** Width is `$clog2(HOLD_CYCLES+1)`.
  - It clears while `state` = 0.
  - It increments each cycle while `state` = 1 and saturates at HOLD_CYCLES.
  - `long_press` goes high on the edge where the hold counter reaches HOLD_CYCLES.
- **Repeat counter.** Width is `$clog2(REPEAT_CYCLES)`, minimum 1.
  - `repeat` pulses on the same edge that `long_press` asserts.
  - It pulses again every REPEAT_CYCLES edges while `long_press` stays high. The repeat counter wraps from REPEAT_CYCLES-1 to 0.
- **End of a press.** On the edge where `state` falls:
  - `long_press` clears.
  - The hold and repeat counters clear.
  - No `repeat` pulse occurs on that edge.
- **Repeat disabled.** With REPEAT_EN=0, `repeat` is constant 0 and the repeat counter is absent.

## Timing
- **Reset.** Asserting `rst_n` low immediately forces every flop to 0, regardless of the clock:
  - sync flops, `state`, and all counters;
  - `press`, `release`, `long_press` and `repeat`.
- **Reset mid-press.** The channel reads as released after reset. It does not produce a `release` pulse.
- **Button held through reset deassertion.** The channel produces a normal `press` STABLE_CYCLES+2 edges after reset deasserts.
- **Debounce latency.** Take a clean input change that is stable before edge 1. Then:
  - `sync2` changes at edge 2;
  - `state` and `press` (or `release`) change at edge 2+STABLE_CYCLES;
  - the pulse drops at edge 3+STABLE_CYCLES.
- **Long-press latency.** If `state` rises at edge P:
  - `long_press` and the first `repeat` occur at edge P+HOLD_CYCLES;
  - later `repeat` pulses occur at P+HOLD_CYCLES+k·REPEAT_CYCLES.
- **STABLE_CYCLES=1.** `state` follows `sync2` with 1 cycle of delay.
- **Simultaneous events.** Simultaneous events on different channels are all reported in the same cycle.

## Test plan
- **Reset.** Hold `rst_n`=0 with `btn`=5'b11111. Required: all outputs 0. Release reset with the buttons still held. Required: `press`=5'b11111 for one cycle at edge 6, then `state`=5'b11111.
- **Clean press and release.** `btn[0]` rises before edge 1. Required: `state[0]` and `press[0]` go high at edge 6, and `press[0]` drops at edge 7. Drop `btn[0]`. Required: `release[0]` pulses exactly 6 edges after the fall is sampled.
- **Glitch rejection.** Bounce `btn[1]` as 3 cycles high, 1 low, 3 high, 1 low. Required: `state[1]` stays 0 with no pulses. Then hold it high for 6 cycles. Required: exactly one `press[1]`.
- **Long press and repeat.** `state[2]` rises at edge P. Required: `long_press[2]` at P+10, `repeat[2]` at P+10, P+13 and P+16. Release. Required: `long_press[2]` clears on the edge `state[2]` falls, with no further `repeat`.
- **REPEAT_EN=0.** Run the same stimulus with REPEAT_EN=0. Required: `long_press` timing unchanged, `repeat` constant 0.
- **Reset mid-hold and multi-channel.** Drive `rst_n` low at P+12. Required: outputs 0 immediately and no `release`. Press channels 3 and 4 in the same cycle. Required: `press`=5'b11000 in a single cycle.

Source files
------------

// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner.
// Each channel is synchronised into clk_oled, debounced by a stability counter and
// converted into registered press/release pulses, a long-press level and an optional
// auto-repeat pulse train. Channels are fully independent.
//
// Ports:
//   clk_oled      - block clock, all flops on the rising edge
//   rst_n         - asynchronous active-low reset, clears every flop
//   btn           - raw asynchronous button levels, 1 = pressed
//   state         - debounced level per channel
//   press         - 1-cycle pulse on each debounced 0->1 transition
//   release_pulse - 1-cycle pulse on each debounced 1->0 transition
//   long_press    - high while the channel has been held for HOLD_CYCLES or more
//   repeat_pulse  - 1-cycle auto-repeat pulses while long-pressed (0 if REPEAT_EN = 0)
module btn_debounce_multi #(
  parameter int unsigned N             = 5,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 10,
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned REPEAT_CYCLES = 3
) (
  input  logic         clk_oled,
  input  logic         rst_n,
  input  logic [N-1:0] btn,
  output logic [N-1:0] state,
  output logic [N-1:0] press,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] long_press,
  output logic [N-1:0] repeat_pulse
);

  localparam int unsigned DW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [DW-1:0] DebLast = DW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HoldMax = HW'(HOLD_CYCLES);
  localparam logic [RW-1:0] RepLast = RW'(REPEAT_CYCLES - 1);

  logic [N-1:0]         sync1_q, sync2_q;
  logic [N-1:0]         state_q, state_d;
  logic [N-1:0]         press_q, press_d;
  logic [N-1:0]         release_q, release_d;
  logic [N-1:0]         long_q, long_d;
  logic [N-1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [N-1:0][HW-1:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = '0;
    press_d    = '0;
    release_d  = '0;
    hold_cnt_d = '0;
    long_d     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // Any matching cycle leaves the counter cleared, restarting the stability window.
      if (sync2_q[i] != state_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          state_d[i] = ~state_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
      press_d[i]   = state_d[i] & ~state_q[i];
      release_d[i] = ~state_d[i] & state_q[i];
      // Count only while already pressed and not falling on this edge, so the count
      // starts the edge after state rises and clears on the falling edge itself.
      if (state_q[i] && state_d[i]) begin
        hold_cnt_d[i] = (hold_cnt_q[i] == HoldMax) ? hold_cnt_q[i] : hold_cnt_q[i] + 1'b1;
      end
      long_d[i] = state_q[i] & state_d[i] & (hold_cnt_d[i] == HoldMax);
    end
  end

  always_ff @(posedge clk_oled or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      state_q    <= '0;
      deb_cnt_q  <= '0;
      press_q    <= '0;
      release_q  <= '0;
      hold_cnt_q <= '0;
      long_q     <= '0;
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      hold_cnt_q <= hold_cnt_d;
      long_q     <= long_d;
    end
  end

  assign state         = state_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;

  if (REPEAT_EN != 0) begin : g_repeat
    logic [N-1:0][RW-1:0] rep_cnt_q, rep_cnt_d;
    logic [N-1:0]         rep_q, rep_d;

    always_comb begin
      rep_cnt_d = '0;
      rep_d     = '0;
      for (int unsigned i = 0; i < N; i++) begin
        if (long_d[i]) begin
          // First pulse coincides with long_press rising, then one per period.
          if (!long_q[i] || (rep_cnt_q[i] == RepLast)) begin
            rep_d[i] = 1'b1;
          end else begin
            rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk_oled or negedge rst_n) begin
      if (!rst_n) begin
        rep_cnt_q <= '0;
        rep_q     <= '0;
      end else begin
        rep_cnt_q <= rep_cnt_d;
        rep_q     <= rep_d;
      end
    end

    assign repeat_pulse = rep_q;
  end else begin : g_no_repeat
    assign repeat_pulse = '0;
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi: one instance with auto-repeat, one without,
// both driven by the same stimulus. Outputs are sampled 1 time unit after each edge.
module tb_btn_debounce_multi;

  logic       clk_oled = 1'b0;
  logic       rst_n;
  logic [4:0] btn;

  logic [4:0] st_a, pr_a, rl_a, lp_a, rp_a;
  logic [4:0] st_b, pr_b, rl_b, lp_b, rp_b;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk_oled = ~clk_oled;

  btn_debounce_multi #(
    .N(5), .STABLE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_EN(1), .REPEAT_CYCLES(3)
  ) u_dut_a (
    .clk_oled     (clk_oled),
    .rst_n        (rst_n),
    .btn          (btn),
    .state        (st_a),
    .press        (pr_a),
    .release_pulse(rl_a),
    .long_press   (lp_a),
    .repeat_pulse (rp_a)
  );

  btn_debounce_multi #(
    .N(5), .STABLE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_EN(0), .REPEAT_CYCLES(3)
  ) u_dut_b (
    .clk_oled     (clk_oled),
    .rst_n        (rst_n),
    .btn          (btn),
    .state        (st_b),
    .press        (pr_b),
    .release_pulse(rl_b),
    .long_press   (lp_b),
    .repeat_pulse (rp_b)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk_oled);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Both instances share every expectation except repeat, which is 0 without auto-repeat.
  task automatic chk_all(input string tag, input logic [4:0] st, input logic [4:0] pr,
                         input logic [4:0] rl, input logic [4:0] lp, input logic [4:0] rp);
    chk({tag, ":state_a"}, st_a, st);
    chk({tag, ":press_a"}, pr_a, pr);
    chk({tag, ":release_a"}, rl_a, rl);
    chk({tag, ":long_a"}, lp_a, lp);
    chk({tag, ":rep_a"}, rp_a, rp);
    chk({tag, ":state_b"}, st_b, st);
    chk({tag, ":press_b"}, pr_b, pr);
    chk({tag, ":release_b"}, rl_b, rl);
    chk({tag, ":long_b"}, lp_b, lp);
    chk({tag, ":rep_b"}, rp_b, 5'b00000);
  endtask

  initial begin
    logic [7:0] gpat;
    int         press_cnt;
    logic [4:0] e_st, e_rl, e_lp, e_rp;

    // Reset held with all buttons pressed.
    rst_n = 1'b0;
    btn   = 5'b11111;
    #12;
    chk_all("rst_hold", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);
    tick(2);
    chk_all("rst_hold2", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);
    rst_n = 1'b1;
    tick(5);  // edge 5
    chk_all("rst_e5", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);
    tick(1);  // edge 6
    chk_all("rst_e6", 5'b11111, 5'b11111, 5'b0, 5'b0, 5'b0);
    tick(1);  // edge 7
    chk_all("rst_e7", 5'b11111, 5'b0, 5'b0, 5'b0, 5'b0);

    // Release everything; held only 7 edges so no long press.
    btn = 5'b00000;
    tick(5);
    chk_all("rel_all_e5", 5'b11111, 5'b0, 5'b0, 5'b0, 5'b0);
    tick(1);
    chk_all("rel_all_e6", 5'b0, 5'b0, 5'b11111, 5'b0, 5'b0);
    tick(1);
    chk_all("rel_all_e7", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);

    // Clean press and release on channel 0.
    btn = 5'b00001;
    tick(5);
    chk_all("ch0_e5", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);
    tick(1);
    chk_all("ch0_e6", 5'b00001, 5'b00001, 5'b0, 5'b0, 5'b0);
    tick(1);
    chk_all("ch0_e7", 5'b00001, 5'b0, 5'b0, 5'b0, 5'b0);
    btn = 5'b00000;
    tick(5);
    chk_all("ch0_rel_e5", 5'b00001, 5'b0, 5'b0, 5'b0, 5'b0);
    tick(1);
    chk_all("ch0_rel_e6", 5'b0, 5'b0, 5'b00001, 5'b0, 5'b0);
    tick(1);
    chk_all("ch0_rel_e7", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);

    // Glitch rejection on channel 1: 3 high, 1 low, 3 high, 1 low (LSB first).
    gpat = 8'b0111_0111;
    for (int i = 0; i < 8; i++) begin
      btn[1] = gpat[i];
      tick(1);
      chk_all($sformatf("glitch_%0d", i), 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);
    end
    btn[1]    = 1'b1;
    press_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      if (pr_a[1]) press_cnt++;
    end
    chk("glitch_press_cnt", 5'(press_cnt), 5'd1);
    chk("glitch_state", st_a, 5'b00010);
    btn = 5'b00000;
    tick(8);
    chk_all("glitch_done", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);

    // Long press and repeat on channel 2; state rises at edge P.
    btn = 5'b00100;
    tick(5);
    chk_all("lp_pre", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);
    tick(1);
    chk_all("lp_P", 5'b00100, 5'b00100, 5'b0, 5'b0, 5'b0);
    for (int k = 1; k <= 25; k++) begin
      tick(1);
      // Button dropped after P+19, so state falls at P+25, exactly a would-be repeat edge.
      e_st = (k < 25) ? 5'b00100 : 5'b00000;
      e_rl = (k == 25) ? 5'b00100 : 5'b00000;
      e_lp = (k >= 10 && k < 25) ? 5'b00100 : 5'b00000;
      e_rp = (k >= 10 && k < 25 && ((k - 10) % 3) == 0) ? 5'b00100 : 5'b00000;
      chk_all($sformatf("lp_P+%0d", k), e_st, 5'b0, e_rl, e_lp, e_rp);
      if (k == 19) btn = 5'b00000;
    end
    tick(3);
    chk_all("lp_after", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);

    // Reset in the middle of a long press.
    btn = 5'b00100;
    tick(6);  // P
    tick(12); // P+12
    chk_all("mid_P+12", 5'b00100, 5'b0, 5'b0, 5'b00100, 5'b0);
    rst_n = 1'b0;
    #1;
    chk_all("mid_rst", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);
    btn = 5'b00000;
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk_all($sformatf("mid_post_%0d", i), 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);
    end

    // Channels 3 and 4 pressed together.
    btn = 5'b11000;
    tick(5);
    chk_all("multi_e5", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);
    tick(1);
    chk_all("multi_e6", 5'b11000, 5'b11000, 5'b0, 5'b0, 5'b0);
    tick(1);
    chk_all("multi_e7", 5'b11000, 5'b0, 5'b0, 5'b0, 5'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
